// File: rtl/inc_ld_arb.sv
// Round-robin load arbiter in front of a shared loadable counter.
// A requester wins ownership and its lane value is sent to the counter with
// a one-cycle ld pulse. Ownership ends when the owner drops req or the hold
// limit runs out. At least one idle cycle always separates two grants.
module inc_ld_arb #(
   parameter int N        = 4,
   parameter int WIDTH    = 8,
   parameter int HOLD_MAX = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N-1:0]           req,
   input  logic [N*WIDTH-1:0]     req_data,
   output logic [N-1:0]           gnt,
   output logic [$clog2(N)-1:0]   owner,
   output logic                   ld,
   output logic [WIDTH-1:0]       data
);

   localparam int IW = $clog2(N);
   localparam int HW = $clog2(HOLD_MAX);

   typedef enum logic [1:0] {IDLE, LOAD, OWN} state_t;

   state_t           state, state_nxt;
   logic [IW-1:0]    ptr, ptr_nxt;
   logic [HW-1:0]    hold_cnt, hold_nxt;
   logic [N-1:0]     gnt_nxt;
   logic [IW-1:0]    owner_nxt;
   logic             ld_nxt;
   logic [WIDTH-1:0] data_nxt;

   logic [WIDTH-1:0] lane [N];
   logic             found;
   logic [IW-1:0]    pick;
   logic [WIDTH-1:0] pick_data;
   logic             release_now;

   // Split the flat load-value bus into one entry per requester.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         lane[i] = req_data[i*WIDTH +: WIDTH];
      end
   end

   // Find the first active request starting at ptr and wrapping; scanning
   // from the far end down lets the closest index to ptr win last.
   always_comb begin
      logic [IW-1:0] idx;
      idx       = '0;
      found     = 1'b0;
      pick      = '0;
      pick_data = '0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr) + k) % N);
         if (req[idx]) begin
            found     = 1'b1;
            pick      = idx;
            pick_data = lane[idx];
         end
      end
   end

   // Ownership ends when the owner lets go or has used its last allowed cycle.
   always_comb begin
      release_now = !req[owner] || (hold_cnt == HW'(HOLD_MAX - 1));
   end

   // Next-state and next-output decisions; the outputs are registered below.
   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      owner_nxt = owner;
      ld_nxt    = 1'b0;
      data_nxt  = data;
      ptr_nxt   = ptr;
      hold_nxt  = hold_cnt;
      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (found) begin
               gnt_nxt   = N'(1) << pick;
               owner_nxt = pick;
               ld_nxt    = 1'b1;
               data_nxt  = pick_data;
               hold_nxt  = '0;
               state_nxt = LOAD;
            end
         end
         LOAD, OWN: begin
            if (release_now) begin
               gnt_nxt   = '0;
               ptr_nxt   = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
               state_nxt = IDLE;
            end else begin
               hold_nxt  = hold_cnt + 1'b1;
               state_nxt = OWN;
            end
         end
         default: begin
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers, all cleared immediately by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= '0;
         owner    <= '0;
         ld       <= 1'b0;
         data     <= '0;
         ptr      <= '0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         owner    <= owner_nxt;
         ld       <= ld_nxt;
         data     <= data_nxt;
         ptr      <= ptr_nxt;
         hold_cnt <= hold_nxt;
      end
   end

endmodule

// File: tb/tb_inc_ld_arb.sv
// Testbench for inc_ld_arb: directed scenarios against fixed expectations,
// then random traffic against a grant-level reference model.
module tb_inc_ld_arb;

   localparam int N     = 4;
   localparam int WIDTH = 8;
   localparam int HOLD  = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [N-1:0]         req = '0;
   logic [N*WIDTH-1:0]   req_data = '0;
   logic [N-1:0]         gnt;
   logic [1:0]           owner;
   logic                 ld;
   logic [WIDTH-1:0]     data;

   int total = 0;
   int bad   = 0;

   // Reference model: who owns the counter, for how many cycles, and where
   // the next search begins.
   int               m_owner;
   int               m_age;
   int               m_ptr;
   int               m_last;
   logic [WIDTH-1:0] m_data;
   logic             m_ld;

   inc_ld_arb #(.N(N), .WIDTH(WIDTH), .HOLD_MAX(HOLD)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .gnt      (gnt),
      .owner    (owner),
      .ld       (ld),
      .data     (data)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic model_reset();
      m_owner = -1;
      m_age   = 0;
      m_ptr   = 0;
      m_last  = 0;
      m_data  = '0;
      m_ld    = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs present at the edge.
   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req[j] && m_owner < 0) begin
               m_owner = j;
               m_last  = j;
               m_age   = 1;
               m_ld    = 1'b1;
               m_data  = req_data[j*WIDTH +: WIDTH];
            end
         end
         if (m_owner < 0) m_ld = 1'b0;
      end else begin
         m_ld = 1'b0;
         if (!req[m_owner] || m_age == HOLD) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end else begin
            m_age++;
         end
      end
   endtask

   function automatic logic [N+1+WIDTH+2-1:0] model_view();
      logic [N-1:0] g;
      g = (m_owner < 0) ? '0 : (N'(1) << m_owner);
      return {g, m_ld, m_data, 2'(m_last)};
   endfunction

   // One clock edge, then settle 1 time unit so outputs are read off-edge.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         req      = N'($urandom);
         req_data = $urandom;
         step();
         total++;
         if ({gnt, ld, data, owner} !== {4'b0000, 1'b0, 8'h00, 2'd0}) begin
            bad++;
            $display("[TB] FAIL reset_hold got gnt=%b ld=%b data=%h owner=%0d want all zero", gnt, ld, data, owner);
         end
      end
      req = '0;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         total++;
         if ({gnt, ld, data, owner} !== {4'b0000, 1'b0, 8'h00, 2'd0}) begin
            bad++;
            $display("[TB] FAIL reset_idle got gnt=%b ld=%b data=%h owner=%0d want all zero", gnt, ld, data, owner);
         end
      end
   endtask

   task automatic test_single_grant();
      req_data = 32'h00A5_0000;
      req      = 4'b0100;
      step();
      total++;
      if ({gnt, ld, data, owner} !== {4'b0100, 1'b1, 8'hA5, 2'd2}) begin
         bad++;
         $display("[TB] FAIL single_first got gnt=%b ld=%b data=%h owner=%0d want 0100/1/a5/2", gnt, ld, data, owner);
      end
      for (int c = 1; c < 5; c++) begin
         step();
         total++;
         if ({gnt, ld, data} !== {4'b0100, 1'b0, 8'hA5}) begin
            bad++;
            $display("[TB] FAIL single_hold got gnt=%b ld=%b data=%h want 0100/0/a5", gnt, ld, data);
         end
      end
      req = 4'b0000;
      step();
      total++;
      if ({gnt, ld, data, owner} !== {4'b0000, 1'b0, 8'hA5, 2'd2}) begin
         bad++;
         $display("[TB] FAIL single_drop got gnt=%b ld=%b data=%h owner=%0d want 0000/0/a5/2", gnt, ld, data, owner);
      end
      req_data = 32'h3300_0011;
      req      = 4'b1001;
      step();
      total++;
      if ({gnt, data, owner} !== {4'b1000, 8'h33, 2'd3}) begin
         bad++;
         $display("[TB] FAIL single_next_ptr got gnt=%b data=%h owner=%0d want 1000/33/3", gnt, data, owner);
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_rotation();
      req_data = 32'h1312_1110;
      req      = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         int o;
         o = g % N;
         for (int c = 0; c < HOLD; c++) begin
            step();
            total++;
            if ({gnt, ld, data, owner} !== {4'(1 << o), (c == 0), 8'(8'h10 + o), 2'(o)}) begin
               bad++;
               $display("[TB] FAIL rotation grant=%0d cycle=%0d got gnt=%b ld=%b data=%h owner=%0d want owner %0d", g, c, gnt, ld, data, owner, o);
            end
         end
         step();
         total++;
         if ({gnt, ld} !== {4'b0000, 1'b0}) begin
            bad++;
            $display("[TB] FAIL rotation_gap grant=%0d got gnt=%b ld=%b want 0000/0", g, gnt, ld);
         end
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_timeout();
      req_data = 32'h0000_0077;
      req      = 4'b0001;
      for (int c = 0; c < HOLD; c++) begin
         step();
         total++;
         if ({gnt, ld} !== {4'b0001, (c == 0)}) begin
            bad++;
            $display("[TB] FAIL timeout_hold cycle=%0d got gnt=%b ld=%b want 0001/%0d", c, gnt, ld, (c == 0));
         end
      end
      step();
      total++;
      if ({gnt, ld} !== {4'b0000, 1'b0}) begin
         bad++;
         $display("[TB] FAIL timeout_gap got gnt=%b ld=%b want 0000/0", gnt, ld);
      end
      step();
      total++;
      if ({gnt, ld, data} !== {4'b0001, 1'b1, 8'h77}) begin
         bad++;
         $display("[TB] FAIL timeout_regrant got gnt=%b ld=%b data=%h want 0001/1/77", gnt, ld, data);
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_drop_load();
      req_data = 32'h0000_5C00;
      req      = 4'b0010;
      step();
      total++;
      if ({gnt, ld, data, owner} !== {4'b0010, 1'b1, 8'h5C, 2'd1}) begin
         bad++;
         $display("[TB] FAIL drop_load_grant got gnt=%b ld=%b data=%h owner=%0d want 0010/1/5c/1", gnt, ld, data, owner);
      end
      req      = 4'b0000;
      req_data = 32'h0000_E700;
      for (int c = 0; c < 2; c++) begin
         step();
         total++;
         if ({gnt, ld, data, owner} !== {4'b0000, 1'b0, 8'h5C, 2'd1}) begin
            bad++;
            $display("[TB] FAIL drop_load_after cycle=%0d got gnt=%b ld=%b data=%h owner=%0d want 0000/0/5c/1", c, gnt, ld, data, owner);
         end
      end
   endtask

   task automatic test_async_reset();
      req_data = 32'h0000_3C00;
      req      = 4'b0010;
      step();
      total++;
      if ({gnt, data} !== {4'b0010, 8'h3C}) begin
         bad++;
         $display("[TB] FAIL async_grant got gnt=%b data=%h want 0010/3c", gnt, data);
      end
      req_data = 32'h0000_FF00;
      step();
      total++;
      if ({gnt, ld, data} !== {4'b0010, 1'b0, 8'h3C}) begin
         bad++;
         $display("[TB] FAIL async_lane_ignored got gnt=%b ld=%b data=%h want 0010/0/3c", gnt, ld, data);
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      total++;
      if ({gnt, ld, data, owner} !== {4'b0000, 1'b0, 8'h00, 2'd0}) begin
         bad++;
         $display("[TB] FAIL async_immediate got gnt=%b ld=%b data=%h owner=%0d want all zero", gnt, ld, data, owner);
      end
      step();
      rst      = 1'b0;
      req      = 4'b1010;
      req_data = 32'h8800_2200;
      step();
      total++;
      if ({gnt, ld, data, owner} !== {4'b0010, 1'b1, 8'h22, 2'd1}) begin
         bad++;
         $display("[TB] FAIL async_first_after got gnt=%b ld=%b data=%h owner=%0d want 0010/1/22/1", gnt, ld, data, owner);
      end
      req = 4'b0000;
      step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, (c < 1500) ? 4 : 30) == 0) req = N'($urandom);
         req_data = $urandom;
         step();
         total++;
         if ({gnt, ld, data, owner} !== model_view()) begin
            bad++;
            $display("[TB] FAIL random cycle=%0d got gnt=%b ld=%b data=%h owner=%0d want %h", c, gnt, ld, data, owner, model_view());
         end
      end
   endtask

   // Run every scenario in order, then report.
   initial begin
      model_reset();
      #2;
      test_reset();
      test_single_grant();
      test_rotation();
      test_timeout();
      test_drop_load();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inc_ld_arb.md
# inc_ld_arb

Round-robin load arbiter sharing one loadable counter (`inc`) among N requesters. Each requester asks for ownership; the winner's load value is presented to the counter with a single-cycle `ld` pulse. The winner keeps ownership until it drops its request or a hold limit expires. The block sits between requester logic and the `ld`/`data` ports of the counter instance. All outputs are registered.

## Interface

Parameters:
- `N`, 4: number of requesters; legal values ≥ 2.
- `WIDTH`, 8: load-value width; matches the counter `data` width.
- `HOLD_MAX`, 16: maximum cycles one grant may last; legal values ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  N  per-requester ownership request, level-sensitive.
- `req_data`  in  N*WIDTH  load values; lane i is `req_data[i*WIDTH +: WIDTH]`.
- `gnt`  out  N  one-hot owner indication; all zero when no owner.
- `owner`  out  $clog2(N)  index of current or last owner.
- `ld`  out  1  load pulse to counter `ld`.
- `data`  out  WIDTH  load value to counter `data`.

## Operation

- The state machine has three states: IDLE, LOAD, and OWN.
- Internal state:
  - `ptr` ($clog2(N)) is the round-robin start index.
  - `hold_cnt` ($clog2(HOLD_MAX)) counts ownership cycles.
- IDLE:
  - If any `req` bit is set at the edge, select the first index j with `req[j]=1`, searching ptr, ptr+1, …, N-1, 0, … (wrapping).
  - Register `gnt` = one-hot(j), `owner` = j, `ld` = 1, `data` = lane j, `hold_cnt` = 0. Go to LOAD.
  - Otherwise stay in IDLE with `gnt` = 0 and `ld` = 0.
- LOAD and OWN (owner i):
  - At each edge, release if `req[i]=0` or `hold_cnt = HOLD_MAX-1`.
  - On release: `gnt` = 0, `ld` = 0, `ptr` = (i+1) mod N, go to IDLE. `owner` and `data` hold their values.
  - Otherwise: `hold_cnt`+1, `ld` = 0, go to (or stay in) OWN.
- `ld` is high only during the LOAD cycle, exactly one cycle per grant.
- `data` is captured at grant time. Later changes on lane i are ignored until the next grant.
- Requests from non-owners are ignored while ownership is held; there is no preemption.
- Inputs are sampled at the edge only. A `req` pulse that falls between edges is not seen.

## Timing

- Grant latency: if `req[j]` is first sampled high at edge k in IDLE, then `gnt`/`ld`/`data` are valid in the cycle after edge k.
- Maximum grant length: `gnt[i]` stays high for at most HOLD_MAX consecutive cycles, counting the LOAD cycle.
- Owner drops `req` during the LOAD cycle: `gnt` is high for exactly 1 cycle.
- Handover: release and re-arbitration never happen on the same edge.
  - At least one cycle with `gnt` = 0 separates successive grants.
  - The throughput limit is one grant per (hold + 1) cycles.
- Single persistent requester that times out: it is released, then re-granted after the 1-cycle gap with a fresh `ld` pulse.
- Simultaneous requests in IDLE: the winner is decided by `ptr` order only. Index order is irrelevant except for the wrap.
- Reset values: `gnt` = 0, `owner` = 0, `ld` = 0, `data` = 0, `ptr` = 0, `hold_cnt` = 0, state = IDLE.
- Reset asserted mid-operation: all outputs go to their reset values immediately (asynchronously, without waiting for a clock edge).
- Reset deassertion: the first arbitration occurs on the first edge after `rst` falls, starting from index 0.

## Test plan

1. **Reset.**
   - Stimulus: `rst`=1 with random `req`.
   - Required: `gnt`=0, `ld`=0, `data`=8'h00, `owner`=0. After release with `req`=0, outputs stay zero.
2. **Single grant and release.**
   - Stimulus: `req`=4'b0100, lane2=8'hA5, then drop `req[2]` after 5 granted cycles.
   - Required: one cycle later `gnt`=4'b0100, `ld`=1 for 1 cycle, `data`=8'hA5, `owner`=2. `gnt` goes to 0 at the edge after the drop. Next arbitration starts at index 3.
3. **Fair rotation.**
   - Stimulus: `req`=4'b1111 held, lanes = 8'h10/11/12/13.
   - Required: grants in order 0,1,2,3,0, each lasting 16 cycles, separated by 1-cycle gaps. One `ld` per grant, with `data` = 8'h10, 11, 12, 13, 10.
4. **Timeout with lone requester.**
   - Stimulus: `req`=4'b0001 held.
   - Required: `gnt[0]` high for 16 cycles, low for 1 cycle, then high again with a second `ld` pulse.
5. **Drop during LOAD.**
   - Stimulus: `req[1]` goes low at the first edge after grant.
   - Required: `gnt[1]` high for exactly 1 cycle and `ld` high for 1 cycle.
   - Additional requirement: changing lane1 after grant does not change `data`.
6. **Async reset mid-OWN.**
   - Stimulus: assert `rst` between edges while `gnt`=4'b0010.
   - Required: `gnt`/`ld`/`data` go to zero immediately. After release with `req`=4'b1010, `gnt`=4'b0010 is issued first, because `ptr` resets to 0 and the search from index 0 reaches index 1 first.
